// File: rtl/alu_acc.sv
// alu_acc: registered ALU with a valid/ready handshake, an accumulator that can
// replace operand A, and {N, V, C, Z} status flags. It accepts one beat per cycle
// and has a latency of 1 cycle.
module alu_acc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       s,
   input  logic             acc_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic [3:0]       flags,
   output logic [WIDTH-1:0] acc
);

   localparam int unsigned MSB = WIDTH - 1;

   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH:0]   wide;
   logic [WIDTH-1:0] result;
   logic             flag_c;
   logic             flag_v;

   // The input side is ready when the result register is empty or is being consumed.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign op_a     = acc_sel ? acc : a;

   // Compute the result and the carry/overflow flags for the current opcode.
   always_comb begin
      wide   = '0;
      result = '0;
      flag_c = 1'b0;
      flag_v = 1'b0;
      case (s)
         3'b000: result = '0;
         3'b001: begin
            // B - A: the upper bit of the widened difference is the borrow.
            wide   = {1'b0, b} - {1'b0, op_a};
            result = wide[MSB:0];
            flag_c = wide[WIDTH];
            flag_v = (b[MSB] != op_a[MSB]) && (result[MSB] != b[MSB]);
         end
         3'b010: begin
            wide   = {1'b0, op_a} - {1'b0, b};
            result = wide[MSB:0];
            flag_c = wide[WIDTH];
            flag_v = (op_a[MSB] != b[MSB]) && (result[MSB] != op_a[MSB]);
         end
         3'b011: begin
            wide   = {1'b0, op_a} + {1'b0, b};
            result = wide[MSB:0];
            flag_c = wide[WIDTH];
            flag_v = (op_a[MSB] == b[MSB]) && (result[MSB] != op_a[MSB]);
         end
         3'b100: result = op_a ^ b;
         3'b101: result = op_a | b;
         3'b110: result = op_a & b;
         3'b111: result = '1;
      endcase
   end

   // The result, flags and accumulator load only when a beat is accepted. At all other times they hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         z     <= '0;
         flags <= '0;
         acc   <= '0;
      end else if (accept) begin
         z     <= result;
         flags <= {result[MSB], flag_v, flag_c, (result == '0)};
         acc   <= result;
      end
   end

   // Set out_valid when a beat is accepted. Clear it when the result is consumed and no new beat arrives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_acc.sv
// Directed testbench for alu_acc. It uses an 8-bit instance for most of the
// checks and a 16-bit instance to check the WIDTH parameter.
module tb_alu_acc;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        in_valid, acc_sel, out_ready;
   logic [7:0]  a, b;
   logic [2:0]  s;
   logic        in_ready, out_valid;
   logic [7:0]  z, acc;
   logic [3:0]  flags;

   logic        in_valid16, acc_sel16, out_ready16;
   logic [15:0] a16, b16;
   logic [2:0]  s16;
   logic        in_ready16, out_valid16;
   logic [15:0] z16, acc16;
   logic [3:0]  flags16;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [7:0] sweep_z [8];
   logic [3:0] sweep_f [8];

   always #5 clk = ~clk;

   alu_acc #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s(s), .acc_sel(acc_sel), .out_valid(out_valid),
      .out_ready(out_ready), .z(z), .flags(flags), .acc(acc)
   );

   alu_acc #(.WIDTH(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .s(s16), .acc_sel(acc_sel16), .out_valid(out_valid16),
      .out_ready(out_ready16), .z(z16), .flags(flags16), .acc(acc16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Expected z and flags ({N,V,C,Z}) for a=0F, b=3C with opcodes 0..7.
      sweep_z = '{8'h00, 8'h2D, 8'hD3, 8'h4B, 8'h33, 8'h3F, 8'h0C, 8'hFF};
      sweep_f = '{4'b0001, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

      reset_n = 1'b0;
      in_valid = 1'b0; acc_sel = 1'b0; out_ready = 1'b1; a = '0; b = '0; s = '0;
      in_valid16 = 1'b0; acc_sel16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; s16 = '0;
      #2;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_z", {24'b0, z}, 32'h0);
      check("rst_flags", {28'b0, flags}, 32'h0);
      check("rst_acc", {24'b0, acc}, 32'h0);
      tick();
      reset_n = 1'b1;

      // Run the opcode sweep at full throughput.
      in_valid = 1'b1; a = 8'h0F; b = 8'h3C;
      for (int unsigned i = 0; i < 8; i++) begin
         s = 3'(i);
         tick();
         check($sformatf("sweep_z_s%0d", i), {24'b0, z}, {24'b0, sweep_z[i]});
         check($sformatf("sweep_f_s%0d", i), {28'b0, flags}, {28'b0, sweep_f[i]});
         check($sformatf("sweep_ov_s%0d", i), {31'b0, out_valid}, 32'd1);
      end

      // Check the flag edge cases.
      a = 8'h7F; b = 8'h01; s = 3'b011;
      tick();
      check("ovf_add_z", {24'b0, z}, 32'h80);
      check("ovf_add_f", {28'b0, flags}, 32'b1100);
      a = 8'hFF; b = 8'h01; s = 3'b011;
      tick();
      check("carry_add_z", {24'b0, z}, 32'h00);
      check("carry_add_f", {28'b0, flags}, 32'b0011);
      a = 8'h80; b = 8'h01; s = 3'b010;
      tick();
      check("ovf_sub_z", {24'b0, z}, 32'h7F);
      check("ovf_sub_f", {28'b0, flags}, 32'b0100);

      // Stall with a pending result, then assert reset in the middle of the stream.
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      check("pre_rst_ov", {31'b0, out_valid}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ov", {31'b0, out_valid}, 32'd0);
      check("mid_rst_z", {24'b0, z}, 32'h0);
      check("mid_rst_flags", {28'b0, flags}, 32'h0);
      check("mid_rst_acc", {24'b0, acc}, 32'h0);
      check("mid_rst_ir", {31'b0, in_ready}, 32'd1);
      #1;
      reset_n = 1'b1;

      // Run the accumulate chain: acc + 1 for five beats with no bubbles.
      out_ready = 1'b1; in_valid = 1'b1; acc_sel = 1'b1; b = 8'h01; s = 3'b011; a = 8'hAA;
      for (int unsigned i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("chain_z_%0d", i), {24'b0, z}, i);
         check($sformatf("chain_ov_%0d", i), {31'b0, out_valid}, 32'd1);
      end
      check("chain_acc", {24'b0, acc}, 32'h05);

      // Apply backpressure for 3 cycles while a beat is offered.
      out_ready = 1'b0;
      #1;
      check("bp_ir", {31'b0, in_ready}, 32'd0);
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_z_%0d", i), {24'b0, z}, 32'h05);
         check($sformatf("bp_acc_%0d", i), {24'b0, acc}, 32'h05);
         check($sformatf("bp_ir_%0d", i), {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("rel_ir", {31'b0, in_ready}, 32'd1);
      tick();
      check("rel_z", {24'b0, z}, 32'h06);
      check("rel_acc", {24'b0, acc}, 32'h06);
      check("rel_ov", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("drain_ov", {31'b0, out_valid}, 32'd0);
      check("drain_z", {24'b0, z}, 32'h06);

      // Check WIDTH = 16: 0x0000 - 0x0001 wraps to 0xFFFF and sets N and C.
      a16 = 16'h0000; b16 = 16'h0001; s16 = 3'b010; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      check("w16_z", {16'b0, z16}, 32'hFFFF);
      check("w16_f", {28'b0, flags16}, 32'b1010);
      check("w16_ov", {31'b0, out_valid16}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
